avalon_pwm_bank: RTL and testbench



---
 rtl/avalon_pwm_bank_if.sv | 12 +
 rtl/avalon_pwm_bank.sv | 163 ++++++++++++++++
 tb/tb_avalon_pwm_bank.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_pwm_bank_if.sv
// Avalon-MM slave bus bundle used by avalon_pwm_bank.
interface avalon_pwm_bank_if;
   logic        chipselect;
   logic [6:0]  address;
   logic        write;
   logic [31:0] writedata;
   logic        read;
   logic [31:0] readdata;

   modport master (output chipselect, address, write, writedata, read, input readdata);
   modport slave  (input chipselect, address, write, writedata, read, output readdata);
endinterface

// File: rtl/avalon_pwm_bank.sv
// Bank of NUM_CH PWM channels behind an Avalon-MM slave; period/duty are
// double-buffered and committed at each channel's own period boundary.
module avalon_pwm_bank #(
   parameter int NUM_CH = 24,
   parameter int CNT_W  = 32
) (
   input  logic              clock,
   input  logic              reset,
   avalon_pwm_bank_if.slave  bus,
   output logic              irq,
   output logic [NUM_CH-1:0] pwm_out
);
   localparam logic [6:0]        ADDR_CTRL     = 7'h00;
   localparam logic [6:0]        ADDR_CH_EN    = 7'h01;
   localparam logic [6:0]        ADDR_UPDATE   = 7'h02;
   localparam logic [6:0]        ADDR_FLAGS    = 7'h03;
   localparam logic [6:0]        ADDR_IRQ_MASK = 7'h04;
   localparam logic [CNT_W-1:0]  CNT_ZERO      = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [NUM_CH-1:0] CH_ZERO       = {NUM_CH{1'b0}};

   logic [1:0]        ctrl_r;
   logic [NUM_CH-1:0] ch_en_r;
   logic [NUM_CH-1:0] pending_r;
   logic [NUM_CH-1:0] flags_r;
   logic [NUM_CH-1:0] irq_mask_r;
   logic [NUM_CH-1:0] pwm_r;
   logic              irq_r;
   logic [31:0]       readdata_r;
   logic [CNT_W-1:0]  period_sh_r  [NUM_CH];
   logic [CNT_W-1:0]  duty_sh_r    [NUM_CH];
   logic [CNT_W-1:0]  period_act_r [NUM_CH];
   logic [CNT_W-1:0]  duty_act_r   [NUM_CH];
   logic [CNT_W-1:0]  cnt_r        [NUM_CH];

   logic              wr_s;
   logic              rd_s;
   logic [4:0]        idx_s;
   logic              idx_ok_s;
   logic              per_sel_s;
   logic              duty_sel_s;
   logic [NUM_CH-1:0] wdata_mask_s;
   logic [NUM_CH-1:0] upd_set_s;
   logic [NUM_CH-1:0] flag_clr_s;
   logic [NUM_CH-1:0] running_s;
   logic [NUM_CH-1:0] wrap_s;
   logic [NUM_CH-1:0] commit_s;
   logic [31:0]       per_rd_s;
   logic [31:0]       duty_rd_s;
   logic [31:0]       rd_data_s;

   assign wr_s         = bus.chipselect & bus.write;
   assign rd_s         = bus.chipselect & bus.read & ~bus.write;
   assign idx_s        = bus.address[4:0];
   assign idx_ok_s     = ({1'b0, idx_s} < 6'(NUM_CH));
   assign per_sel_s    = idx_ok_s & (bus.address[6:5] == 2'b01);
   assign duty_sel_s   = idx_ok_s & (bus.address[6:5] == 2'b10);
   assign wdata_mask_s = bus.writedata[NUM_CH-1:0];
   assign upd_set_s    = (wr_s && (bus.address == ADDR_UPDATE)) ? wdata_mask_s : CH_ZERO;
   assign flag_clr_s   = (wr_s && (bus.address == ADDR_FLAGS))  ? wdata_mask_s : CH_ZERO;

   assign bus.readdata = readdata_r;
   assign irq          = irq_r;
   assign pwm_out      = pwm_r;

   // Per-channel run, wrap and commit decisions from the current state.
   always_comb begin
      running_s = CH_ZERO;
      wrap_s    = CH_ZERO;
      commit_s  = CH_ZERO;
      for (int i = 0; i < NUM_CH; i++) begin
         running_s[i] = ctrl_r[0] & ch_en_r[i] & (period_act_r[i] != CNT_ZERO);
         wrap_s[i]    = running_s[i] & (cnt_r[i] >= (period_act_r[i] - CNT_ONE));
         commit_s[i]  = pending_r[i] & (wrap_s[i] | ~running_s[i]);
      end
   end

   // Read multiplexer; unmapped and out-of-range channel addresses return 0.
   always_comb begin
      per_rd_s  = 32'd0;
      duty_rd_s = 32'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         per_rd_s  = per_rd_s  | ((idx_s == 5'(i)) ? 32'(period_sh_r[i]) : 32'd0);
         duty_rd_s = duty_rd_s | ((idx_s == 5'(i)) ? 32'(duty_sh_r[i])   : 32'd0);
      end
      case (bus.address)
         ADDR_CTRL:     rd_data_s = {30'd0, ctrl_r};
         ADDR_CH_EN:    rd_data_s = 32'(ch_en_r);
         ADDR_UPDATE:   rd_data_s = 32'(pending_r);
         ADDR_FLAGS:    rd_data_s = 32'(flags_r);
         ADDR_IRQ_MASK: rd_data_s = 32'(irq_mask_r);
         default:       rd_data_s = per_sel_s ? per_rd_s : (duty_sel_s ? duty_rd_s : 32'd0);
      endcase
   end

   // Bus-visible registers; set beats clear on both pending and flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         ctrl_r     <= 2'b00;
         ch_en_r    <= CH_ZERO;
         irq_mask_r <= CH_ZERO;
         pending_r  <= CH_ZERO;
         flags_r    <= CH_ZERO;
         for (int i = 0; i < NUM_CH; i++) begin
            period_sh_r[i] <= CNT_ZERO;
            duty_sh_r[i]   <= CNT_ZERO;
         end
      end else begin
         if (wr_s) begin
            case (bus.address)
               ADDR_CTRL:     ctrl_r     <= bus.writedata[1:0];
               ADDR_CH_EN:    ch_en_r    <= wdata_mask_s;
               ADDR_IRQ_MASK: irq_mask_r <= wdata_mask_s;
               default:       ;
            endcase
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_s && per_sel_s && (idx_s == 5'(i)))
               period_sh_r[i] <= bus.writedata[CNT_W-1:0];
            if (wr_s && duty_sel_s && (idx_s == 5'(i)))
               duty_sh_r[i] <= bus.writedata[CNT_W-1:0];
         end
         pending_r <= (pending_r & ~commit_s) | upd_set_s;
         flags_r   <= (flags_r & ~flag_clr_s) | wrap_s;
      end
   end

   // Channel counters, active period/duty and PWM outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         pwm_r <= CH_ZERO;
         for (int i = 0; i < NUM_CH; i++) begin
            period_act_r[i] <= CNT_ZERO;
            duty_act_r[i]   <= CNT_ZERO;
            cnt_r[i]        <= CNT_ZERO;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (commit_s[i]) begin
               period_act_r[i] <= period_sh_r[i];
               duty_act_r[i]   <= duty_sh_r[i];
            end
            if (running_s[i] && !wrap_s[i])
               cnt_r[i] <= cnt_r[i] + CNT_ONE;
            else
               cnt_r[i] <= CNT_ZERO;
            pwm_r[i] <= running_s[i] & (cnt_r[i] < duty_act_r[i]);
         end
      end
   end

   // Registered interrupt and read data.
   always_ff @(posedge clock) begin
      if (reset) begin
         irq_r      <= 1'b0;
         readdata_r <= 32'd0;
      end else begin
         irq_r <= ctrl_r[1] & (|(flags_r & irq_mask_r));
         if (rd_s)
            readdata_r <= rd_data_s;
      end
   end
endmodule

// File: tb/tb_avalon_pwm_bank.sv
// Self-checking bench for avalon_pwm_bank: register vectors, directed PWM
// sequences and random bus traffic against a cycle-level reference model.
module tb_avalon_pwm_bank;
   localparam int NCH = 24;
   localparam int CW  = 32;

   typedef struct {
      string       name;
      logic [6:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } reg_vec_t;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           irq;
   logic [NCH-1:0] pwm_out;

   avalon_pwm_bank_if bus();

   avalon_pwm_bank #(.NUM_CH(NCH), .CNT_W(CW)) dut (
      .clock   (clock),
      .reset   (reset),
      .bus     (bus),
      .irq     (irq),
      .pwm_out (pwm_out)
   );

   always #5 clock = ~clock;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state (values after the most recent clock edge).
   logic [1:0]     m_ctrl;
   logic [NCH-1:0] m_en, m_pend, m_flags, m_mask, m_pwm;
   logic           m_irq;
   logic [31:0]    m_rdata;
   longint         m_psh[NCH], m_dsh[NCH], m_pact[NCH], m_dact[NCH], m_cnt[NCH];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input int a);
      if (a == 0)                         return {30'd0, m_ctrl};
      else if (a == 1)                    return 32'(m_en);
      else if (a == 2)                    return 32'(m_pend);
      else if (a == 3)                    return 32'(m_flags);
      else if (a == 4)                    return 32'(m_mask);
      else if (a >= 32 && a < 32 + NCH)   return m_psh[a-32][31:0];
      else if (a >= 64 && a < 64 + NCH)   return m_dsh[a-64][31:0];
      else                                return 32'd0;
   endfunction

   // One bus cycle: drive inputs, advance the model, compare after the edge.
   task automatic tick(input logic rst, input logic cs, input logic [6:0] a,
                       input logic wr, input logic [31:0] wd, input logic rd);
      logic [NCH-1:0] n_pend, n_flags, n_pwm, wmask;
      logic [31:0]    n_rdata;
      logic           n_irq, do_wr;
      longint         n_pact[NCH], n_dact[NCH], n_cnt[NCH];
      int             ai;
      reset = rst; bus.chipselect = cs; bus.address = a;
      bus.write = wr; bus.writedata = wd; bus.read = rd;
      ai      = int'(a);
      do_wr   = cs & wr;
      wmask   = wd[NCH-1:0];
      n_rdata = (cs && rd && !wr) ? m_read(ai) : m_rdata;
      n_irq   = m_ctrl[1] && ((m_flags & m_mask) != 0);
      n_pend  = m_pend;
      n_flags = m_flags;
      for (int i = 0; i < NCH; i++) begin
         bit run, wrap;
         run       = m_ctrl[0] && m_en[i] && (m_pact[i] != 0);
         wrap      = run && (m_cnt[i] + 1 >= m_pact[i]);
         n_pwm[i]  = run && (m_cnt[i] < m_dact[i]);
         n_cnt[i]  = (run && !wrap) ? m_cnt[i] + 1 : 0;
         n_pact[i] = m_pact[i];
         n_dact[i] = m_dact[i];
         if (m_pend[i] && (wrap || !run)) begin
            n_pact[i] = m_psh[i];
            n_dact[i] = m_dsh[i];
            n_pend[i] = 1'b0;
         end
         if (wrap) n_flags[i] = 1'b1;
         else if (do_wr && ai == 3 && wd[i]) n_flags[i] = 1'b0;
      end
      if (do_wr && ai == 2) n_pend = n_pend | wmask;
      @(posedge clock);
      if (rst) begin
         m_ctrl = 2'b00; m_en = '0; m_pend = '0; m_flags = '0; m_mask = '0;
         m_pwm = '0; m_irq = 1'b0; m_rdata = 32'd0;
         for (int i = 0; i < NCH; i++) begin
            m_psh[i] = 0; m_dsh[i] = 0; m_pact[i] = 0; m_dact[i] = 0; m_cnt[i] = 0;
         end
      end else begin
         m_rdata = n_rdata; m_irq = n_irq; m_pend = n_pend; m_flags = n_flags; m_pwm = n_pwm;
         for (int i = 0; i < NCH; i++) begin
            m_pact[i] = n_pact[i]; m_dact[i] = n_dact[i]; m_cnt[i] = n_cnt[i];
         end
         if (do_wr) begin
            if (ai == 0)                          m_ctrl = wd[1:0];
            else if (ai == 1)                     m_en   = wmask;
            else if (ai == 4)                     m_mask = wmask;
            else if (ai >= 32 && ai < 32 + NCH)   m_psh[ai-32] = longint'(wd);
            else if (ai >= 64 && ai < 64 + NCH)   m_dsh[ai-64] = longint'(wd);
         end
      end
      #1;
      check("pwm_out", pwm_out, m_pwm);
      check("irq", irq, m_irq);
      check("readdata", bus.readdata, m_rdata);
   endtask

   task automatic idle();                                   tick(1'b0, 1'b0, 7'h00, 1'b0, 32'd0, 1'b0); endtask
   task automatic wr(input logic [6:0] a, input logic [31:0] d); tick(1'b0, 1'b1, a, 1'b1, d, 1'b0); endtask
   task automatic rd(input logic [6:0] a);                  tick(1'b0, 1'b1, a, 1'b0, 32'd0, 1'b1); endtask
   task automatic do_reset();                               tick(1'b1, 1'b0, 7'h00, 1'b0, 32'd0, 1'b0); endtask

   task automatic wait_cnt(input int ch, input longint v);
      int n = 0;
      while (m_cnt[ch] != v && n < 200) begin idle(); n++; end
      check("wait_cnt_bound", 64'(m_cnt[ch] == v), 64'd1);
   endtask

   task automatic wait_pend_clear(input int ch);
      int n = 0;
      while (m_pend[ch] && n < 200) begin idle(); n++; end
      check("wait_pend_bound", 64'(m_pend[ch]), 64'd0);
   endtask

   task automatic wait_flag(input int ch);
      int n = 0;
      while (!m_flags[ch] && n < 200) begin idle(); n++; end
      check("wait_flag_bound", 64'(m_flags[ch]), 64'd1);
   endtask

   initial begin
      reg_vec_t    vecs[11];
      logic [19:0] got20, exp20;
      logic [11:0] got12;
      logic [6:0]  ra;
      logic [31:0] rw;
      int          r, sel, ch;

      vecs[0]  = '{"ctrl_bits",      7'h00, 32'hFFFF_FFFF, 32'h0000_0003};
      vecs[1]  = '{"ch_en_mask",     7'h01, 32'hFFFF_FFFF, 32'h00FF_FFFF};
      vecs[2]  = '{"irq_mask",       7'h04, 32'hA5A5_A5A5, 32'h00A5_A5A5};
      vecs[3]  = '{"period_sh0",     7'h20, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[4]  = '{"duty_sh23",      7'h57, 32'h0000_0042, 32'h0000_0042};
      vecs[5]  = '{"period_sh30",    7'h3E, 32'h0000_1234, 32'h0000_0000};
      vecs[6]  = '{"unmapped_05",    7'h05, 32'h0000_FFFF, 32'h0000_0000};
      vecs[7]  = '{"unmapped_7f",    7'h7F, 32'h0000_0001, 32'h0000_0000};
      vecs[8]  = '{"duty_sh24",      7'h58, 32'h0000_0007, 32'h0000_0000};
      vecs[9]  = '{"flags_w1c_idle", 7'h03, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[10] = '{"update_pending", 7'h02, 32'hFF00_0003, 32'h0000_0003};

      do_reset(); do_reset();
      check("reset_pwm", pwm_out, 64'd0);
      check("reset_irq", irq, 64'd0);
      check("reset_rdata", bus.readdata, 64'd0);

      foreach (vecs[k]) begin
         wr(vecs[k].addr, vecs[k].wdata);
         rd(vecs[k].addr);
         check(vecs[k].name, bus.readdata, vecs[k].exp);
      end

      // Basic channel 10/3.
      do_reset();
      wr(7'h20, 32'd10); wr(7'h40, 32'd3); wr(7'h02, 32'd1); wr(7'h01, 32'd1); wr(7'h00, 32'd1);
      for (int k = 0; k < 20; k++) begin
         idle();
         got20[k] = pwm_out[0];
         exp20[k] = ((k % 10) < 3);
      end
      check("basic_pattern", got20, exp20);
      rd(7'h03);
      check("basic_flag", bus.readdata[0], 64'd1);

      // Glitch-free duty change mid-period.
      wait_cnt(0, 2);
      wr(7'h40, 32'd6);
      wr(7'h02, 32'd1);
      wait_pend_clear(0);
      for (int k = 0; k < 10; k++) begin
         if (k == 0) rd(7'h02); else idle();
         if (k == 0) check("upd_read_after_wrap", bus.readdata, 64'd0);
         got20[k] = pwm_out[0];
      end
      check("new_shape_6_4", got20[9:0], 64'h03F);

      // Duty extremes and zero period.
      wr(7'h40, 32'd0); wr(7'h02, 32'd1); wait_pend_clear(0);
      for (int k = 0; k < 12; k++) begin idle(); got12[k] = pwm_out[0]; end
      check("duty0_low", got12, 64'h000);
      wr(7'h40, 32'd15); wr(7'h02, 32'd1); wait_pend_clear(0);
      for (int k = 0; k < 12; k++) begin idle(); got12[k] = pwm_out[0]; end
      check("duty15_high", got12, 64'hFFF);
      wr(7'h20, 32'd0); wr(7'h02, 32'd1); wait_pend_clear(0);
      for (int k = 0; k < 12; k++) begin idle(); got12[k] = pwm_out[0]; end
      check("period0_low", got12, 64'h000);
      wr(7'h40, 32'd5); wr(7'h02, 32'd1);
      rd(7'h02);
      check("period0_pending_seen", bus.readdata, 64'd1);
      rd(7'h02);
      check("period0_commit_now", bus.readdata, 64'd0);

      // Interrupt on channel 2.
      do_reset();
      wr(7'h22, 32'd5); wr(7'h42, 32'd2); wr(7'h02, 32'd4);
      wr(7'h04, 32'd4); wr(7'h01, 32'd4); wr(7'h00, 32'd3);
      wait_flag(2);
      check("irq_lag", irq, 64'd0);
      idle();
      check("irq_rise", irq, 64'd1);
      wait_cnt(2, 4);
      wr(7'h03, 32'd4);
      rd(7'h03);
      check("flag_set_wins", bus.readdata, 64'd4);
      check("irq_hold", irq, 64'd1);
      wait_cnt(2, 1);
      wr(7'h03, 32'd4);
      check("irq_clear_lag", irq, 64'd1);
      idle();
      check("irq_fall", irq, 64'd0);

      // Bus edge cases.
      rd(7'h00);
      rd(7'h7F);
      check("read_unmapped", bus.readdata, 64'd0);
      wr(7'h3E, 32'd7);
      rd(7'h3E);
      check("write_ch30_ignored", bus.readdata, 64'd0);
      rd(7'h00);
      tick(1'b0, 1'b1, 7'h00, 1'b1, 32'd1, 1'b1);
      check("rw_keep_rdata", bus.readdata, 64'd3);
      rd(7'h00);
      check("rw_write_lands", bus.readdata, 64'd1);

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         r   = $urandom_range(0, 99);
         sel = $urandom_range(0, 9);
         ch  = $urandom_range(0, 31);
         if (sel <= 4)      ra = 7'(sel);
         else if (sel <= 6) ra = 7'(32 + ch);
         else if (sel <= 8) ra = 7'(64 + ch);
         else               ra = 7'($urandom_range(0, 127));
         rw = (ra >= 7'h20 && ra < 7'h60) ? 32'($urandom_range(0, 12)) : 32'($urandom);
         if (r < 1)       do_reset();
         else if (r < 45) idle();
         else if (r < 70) wr(ra, rw);
         else if (r < 90) rd(ra);
         else if (r < 95) tick(1'b0, 1'b1, ra, 1'b1, rw, 1'b1);
         else             tick(1'b0, 1'b0, ra, 1'b1, rw, 1'b1);
      end

      // Reset while every channel is running.
      do_reset();
      for (int i = 0; i < NCH; i++) begin
         wr(7'(32 + i), 32'(3 + i % 5));
         wr(7'(64 + i), 32'd2);
      end
      wr(7'h02, 32'h00FF_FFFF); wr(7'h04, 32'h00FF_FFFF);
      wr(7'h01, 32'h00FF_FFFF); wr(7'h00, 32'd3);
      for (int k = 0; k < 20; k++) idle();
      rd(7'h00);
      do_reset();
      check("midreset_pwm", pwm_out, 64'd0);
      check("midreset_irq", irq, 64'd0);
      check("midreset_rdata", bus.readdata, 64'd0);
      foreach (vecs[k]) begin
         rd(vecs[k].addr);
         check("midreset_reg", bus.readdata, 64'd0);
      end
      rd(7'h25);
      check("midreset_period5", bus.readdata, 64'd0);
      rd(7'h02);
      check("midreset_pending", bus.readdata, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
